// File: rtl/fp_adder.sv
// Two-stage IEEE-754 single-precision adder, truncating, flush-to-zero.
// Stage 1 registers operands; stage 2 registers the normalised sum.
module fp_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out,
  output logic        overflow
);

  logic [31:0] a_q, b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (enable) begin
      a_q <= in1;
      b_q <= in2;
    end
  end

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        zero_a, zero_b, a_big;
  logic [30:0] mag_a, mag_b;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  assign nan_a  = (ea == 8'hff) && (fa != '0);
  assign nan_b  = (eb == 8'hff) && (fb != '0);
  assign inf_a  = (ea == 8'hff) && (fa == '0);
  assign inf_b  = (eb == 8'hff) && (fb == '0);
  assign zero_a = (ea == 8'h00);
  assign zero_b = (eb == 8'h00);

  // Denormals compare as zero so the swap agrees with the flush.
  assign mag_a = zero_a ? '0 : {ea, fa};
  assign mag_b = zero_b ? '0 : {eb, fb};
  assign a_big = mag_a >= mag_b;

  logic        s_l;
  logic [7:0]  e_l, e_s, ediff;
  logic [26:0] m_l, m_s, m_sh, mask;
  logic        sticky, same;
  logic [27:0] sum;
  logic [26:0] norm;
  logic [4:0]  lz;
  logic        found;
  logic signed [9:0] er;
  logic [31:0] res;
  logic        res_ovf;

  always_comb begin
    s_l   = a_big ? sa : sb;
    e_l   = a_big ? ea : eb;
    e_s   = a_big ? eb : ea;
    m_l   = a_big ? mag_a[30:23] == 8'h00 ? '0 : {1'b1, fa, 3'b000}
                  : mag_b[30:23] == 8'h00 ? '0 : {1'b1, fb, 3'b000};
    m_s   = a_big ? mag_b[30:23] == 8'h00 ? '0 : {1'b1, fb, 3'b000}
                  : mag_a[30:23] == 8'h00 ? '0 : {1'b1, fa, 3'b000};
    same  = (sa == sb);
    ediff = e_l - e_s;
    mask  = '0;
    m_sh  = '0;
    if (ediff < 8'd26) begin
      mask = (27'd1 << ediff) - 27'd1;
      m_sh = m_s >> ediff;
    end
    sticky = (ediff < 8'd26) && ((m_s & mask) != '0);
    m_sh[0] = m_sh[0] | sticky;

    if (same) sum = {1'b0, m_l} + {1'b0, m_sh};
    else      sum = {1'b0, m_l} - {1'b0, m_sh};

    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    er = signed'({2'b00, e_l});
    if (sum[27]) begin
      norm = sum[27:1];
      er   = er + 10'sd1;
    end else begin
      norm = sum[26:0] << lz;
      er   = er - signed'({5'b0, lz});
    end

    res     = '0;
    res_ovf = 1'b0;
    if (nan_a || nan_b) begin
      res = 32'h7fc00000;
    end else if (inf_a && inf_b && (sa != sb)) begin
      res = 32'h7fc00000;
    end else if (inf_a) begin
      res     = a_q;
      res_ovf = 1'b1;
    end else if (inf_b) begin
      res     = b_q;
      res_ovf = 1'b1;
    end else if (zero_a && zero_b) begin
      res = {sa & sb, 31'd0};
    end else if (sum == '0) begin
      res = '0;
    end else if (er >= 10'sd255) begin
      res     = {s_l, 8'hff, 23'd0};
      res_ovf = 1'b1;
    end else if (er <= 10'sd0) begin
      res = {s_l, 31'd0};
    end else begin
      res = {s_l, er[7:0], norm[25:3]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out      <= '0;
      overflow <= 1'b0;
    end else if (enable) begin
      out      <= res;
      overflow <= res_ovf;
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed bench for fp_adder: reset, latency, specials, hold.
// Each vector waits two enabled edges before sampling.
module tb_fp_adder;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] in1, in2;
  logic [31:0] out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  fp_adder dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] eo,
                     input logic eovf);
    checks++;
    assert (out === eo) else begin
      errors++;
      $error("FAIL %s out=%h expected=%h", tag, out, eo);
    end
    checks++;
    assert (overflow === eovf) else begin
      errors++;
      $error("FAIL %s_ovf overflow=%b expected=%b", tag, overflow, eovf);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eo,
                     input logic eovf);
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    @(posedge clk);
    #1 chk(tag, eo, eovf);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    in1    = 32'h3f800000;
    in2    = 32'h3f800000;
    #1 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("reset", 32'h0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    in1   = 32'h3fa00000;
    in2   = 32'h40200000;
    @(posedge clk);
    #1 chk("lat1", 32'h0, 1'b0);
    @(posedge clk);
    #1 chk("lat2", 32'h40700000, 1'b0);

    run("inf_p1",   32'h7f800000, 32'h3f800000, 32'h7f800000, 1'b1);
    run("ninf_n1",  32'hff800000, 32'hbf800000, 32'hff800000, 1'b1);
    run("sub",      32'h3fc00000, 32'hc0b00000, 32'hc0800000, 1'b0);
    run("sub_comm", 32'hc0b00000, 32'h3fc00000, 32'hc0800000, 1'b0);
    run("add",      32'h3fa00000, 32'h40200000, 32'h40700000, 1'b0);
    run("add_neg",  32'hbfa00000, 32'hc0200000, 32'hc0700000, 1'b0);
    run("zero_x",   32'h00000000, 32'h3f99999a, 32'h3f99999a, 1'b0);
    run("x_zero",   32'h3f99999a, 32'h00000000, 32'h3f99999a, 1'b0);
    run("cancel",   32'h3f800000, 32'hbf800000, 32'h00000000, 1'b0);
    run("big_ovf",  32'h7f7fffff, 32'h7f7fffff, 32'h7f800000, 1'b1);
    run("inf_ninf", 32'h7f800000, 32'hff800000, 32'h7fc00000, 1'b0);
    run("nan",      32'h7fc00001, 32'h3f800000, 32'h7fc00000, 1'b0);
    run("one_one",  32'h3f800000, 32'h3f800000, 32'h40000000, 1'b0);
    run("nz_nz",    32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    run("pz_nz",    32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    run("denorm",   32'h00000001, 32'h3f800000, 32'h3f800000, 1'b0);
    run("underflw", 32'h00800000, 32'h80800001, 32'h80000000, 1'b0);
    run("tiny",     32'h3f800000, 32'h33000000, 32'h3f800000, 1'b0);
    run("far",      32'h3f800000, 32'h32800000, 32'h3f800000, 1'b0);
    run("hold_pre", 32'h7f800000, 32'h3f800000, 32'h7f800000, 1'b1);

    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clk);
    end
    chk("hold", 32'h7f800000, 1'b1);

    @(negedge clk);
    enable = 1'b1;
    run("resume",   32'h3fc00000, 32'hc0b00000, 32'hc0800000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
